fir_decim: RTL and testbench

- Downstream stage of the FIR filter. Consumes the filtered sample stream `Y` and applies boxcar averaging over 2^LOG2M samples.
- Decimates by 2^LOG2M with round-half-up.
- Delivers results through a show-ahead output FIFO with a valid/ready handshake and a sticky overflow flag.
- Sits between the FIR and any rate-reduced consumer (CORDIC core, capture logic).

---
 rtl/fir_decim.sv | 138 +++++++++++++
 tb/tb_fir_decim.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fir_decim.sv
// Boxcar decimator for the FIR output stream: sums 2^LOG2M samples,
// rounds half-up, and queues results in a show-ahead FIFO.
module fir_decim #(
    parameter int BW    = 12,
    parameter int LOG2M = 2,
    parameter int LOG2D = 2
) (
    input  logic          CK,
    input  logic          R,
    input  logic          EN,
    input  logic [BW-1:0] X,
    input  logic          CLR,
    output logic [BW-1:0] Y_DATA,
    output logic          Y_VALID,
    input  logic          Y_READY,
    output logic          OVF,
    output logic [LOG2D:0] LEVEL
);

    localparam int M  = 1 << LOG2M;
    localparam int D  = 1 << LOG2D;
    localparam int AW = BW + LOG2M + 1;
    localparam int PW = (LOG2M > 0) ? LOG2M : 1;

    localparam logic [PW-1:0]  PLAST = PW'(M - 1);
    localparam logic [AW-1:0]  HALF  = AW'(M / 2);
    localparam logic [LOG2D:0] FULLV = (LOG2D + 1)'(D);

    logic [PW-1:0]    r_phase;
    logic [AW-1:0]    r_acc;
    logic [BW-1:0]    r_mem [D];
    logic [LOG2D-1:0] r_wp;
    logic [LOG2D-1:0] r_rp;
    logic [LOG2D:0]   r_level;
    logic             r_valid;
    logic             r_ovf;
    logic [BW-1:0]    r_ydata;

    logic             w_accept;
    logic             w_last;
    logic [AW-1:0]    w_xs;
    logic [AW-1:0]    w_base;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_rnd;
    logic [BW-1:0]    w_res;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic [LOG2D-1:0] w_rp1;
    logic [LOG2D:0]   w_level;
    logic [BW-1:0]    w_head;

    assign w_accept = EN & ~CLR;
    assign w_last   = (r_phase == PLAST);
    assign w_xs     = {{(LOG2M + 1){X[BW-1]}}, X};
    // Phase 0 starts a fresh sum, which also covers M=1 (acc treated as 0).
    assign w_base   = (r_phase == '0) ? '0 : r_acc;
    assign w_sum    = w_base + w_xs;
    assign w_rnd    = w_sum + HALF;
    assign w_res    = BW'($signed(w_rnd) >>> LOG2M);

    assign w_push = w_accept & w_last;
    assign w_pop  = r_valid & Y_READY;
    assign w_full = (r_level == FULLV);
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_rp1  = r_rp + 1'b1;

    always_comb begin
        w_level = r_level;
        case ({w_wr, w_pop})
            2'b10:   w_level = r_level + 1'b1;
            2'b01:   w_level = r_level - 1'b1;
            default: w_level = r_level;
        endcase
    end

    // Registered head: the next head is chosen before the edge so Y_DATA
    // is a flop and simply holds its value once the FIFO runs dry.
    always_comb begin
        w_head = r_ydata;
        if (w_pop) begin
            if (r_level > 1)
                w_head = r_mem[w_rp1];
            else if (w_wr)
                w_head = w_res;
        end else if (!r_valid && w_wr) begin
            w_head = w_res;
        end
    end

    always_ff @(posedge CK) begin
        if (R) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else if (CLR) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else if (EN) begin
            r_phase <= w_last ? '0 : r_phase + 1'b1;
            r_acc   <= w_sum;
        end
    end

    always_ff @(posedge CK) begin
        if (w_wr && !R)
            r_mem[r_wp] <= w_res;
    end

    always_ff @(posedge CK) begin
        if (R) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_ydata <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= w_rp1;
            r_level <= w_level;
            r_valid <= (w_level != '0);
            r_ydata <= w_head;
            if (CLR)
                r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    assign Y_DATA  = r_ydata;
    assign Y_VALID = r_valid;
    assign OVF     = r_ovf;
    assign LEVEL   = r_level;

endmodule

// File: tb/tb_fir_decim.sv
// Scoreboard bench for fir_decim: expected results are queued as the
// M-th sample is driven and retired as the DUT pops them.
module tb_fir_decim;

    logic        CK = 1'b0;
    logic        R;
    logic        EN;
    logic [11:0] X;
    logic        CLR;
    logic [11:0] Y_DATA;
    logic        Y_VALID;
    logic        Y_READY;
    logic        OVF;
    logic [2:0]  LEVEL;

    int mq[$];
    int m_ovf;
    int m_phase;
    int m_last;
    int nxt_exp;
    int checks;
    int errors;

    fir_decim #(.BW(12), .LOG2M(2), .LOG2D(2)) dut (
        .CK(CK),
        .R(R),
        .EN(EN),
        .X(X),
        .CLR(CLR),
        .Y_DATA(Y_DATA),
        .Y_VALID(Y_VALID),
        .Y_READY(Y_READY),
        .OVF(OVF),
        .LEVEL(LEVEL)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input int x,
                        input logic clr, input logic rdy);
        int  got_d;
        bit  full;
        bit  pop;
        R       = r;
        EN      = en;
        X       = x[11:0];
        CLR     = clr;
        Y_READY = rdy;
        got_d   = $signed(Y_DATA);
        chk("level", int'(LEVEL), mq.size());
        chk("valid", int'(Y_VALID), (mq.size() > 0) ? 1 : 0);
        chk("ovf", int'(OVF), m_ovf);
        if (mq.size() > 0)
            chk("data", got_d, mq[0]);
        else
            chk("hold", got_d, m_last);
        if (r) begin
            mq.delete();
            m_ovf   = 0;
            m_phase = 0;
            m_last  = 0;
        end else begin
            full = (mq.size() == 4);
            pop  = (mq.size() > 0) && rdy;
            if (pop)
                m_last = mq.pop_front();
            if (clr) begin
                m_phase = 0;
                m_ovf   = 0;
            end else if (en) begin
                if (m_phase == 3) begin
                    m_phase = 0;
                    if (full && !pop)
                        m_ovf = 1;
                    else
                        mq.push_back(nxt_exp);
                end else begin
                    m_phase++;
                end
            end
        end
        @(posedge CK);
        #1;
    endtask

    task automatic burst(input int a, input int b, input int c, input int d,
                         input int exp, input logic rdy);
        nxt_exp = exp;
        step(1'b0, 1'b1, a, 1'b0, rdy);
        step(1'b0, 1'b1, b, 1'b0, rdy);
        step(1'b0, 1'b1, c, 1'b0, rdy);
        step(1'b0, 1'b1, d, 1'b0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 0, 1'b0, rdy);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_ovf   = 0;
        m_phase = 0;
        m_last  = 0;
        nxt_exp = 0;
        R       = 1'b1;
        EN      = 1'b1;
        X       = 12'd500;
        CLR     = 1'b0;
        Y_READY = 1'b1;
        @(posedge CK);
        #1;
        step(1'b1, 1'b1, 500, 1'b0, 1'b1);
        step(1'b1, 1'b1, 500, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);

        burst(100, 101, 102, 103, 102, 1'b1);
        idle(2, 1'b1);
        burst(-1, -2, -1, -2, -1, 1'b1);
        idle(2, 1'b1);

        burst(2047, 2047, 2047, 2047, 2047, 1'b1);
        burst(-2048, -2048, -2048, -2048, -2048, 1'b1);
        burst(1, 1, 0, 0, 1, 1'b1);
        burst(-1, -1, 0, 0, 0, 1'b1);
        idle(2, 1'b1);

        nxt_exp = 25;
        step(1'b0, 1'b1, 10, 1'b0, 1'b1);
        step(1'b0, 1'b0, 999, 1'b0, 1'b1);
        step(1'b0, 1'b1, 20, 1'b0, 1'b1);
        step(1'b0, 1'b0, 999, 1'b0, 1'b1);
        step(1'b0, 1'b0, 999, 1'b0, 1'b1);
        step(1'b0, 1'b1, 30, 1'b0, 1'b1);
        step(1'b0, 1'b0, 999, 1'b0, 1'b1);
        step(1'b0, 1'b1, 40, 1'b0, 1'b1);
        idle(2, 1'b1);

        for (int k = 1; k <= 5; k++)
            burst(k, k, k, k, k, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b1);
        idle(1, 1'b1);

        for (int k = 11; k <= 14; k++)
            burst(k, k, k, k, k, 1'b0);
        nxt_exp = 15;
        step(1'b0, 1'b1, 15, 1'b0, 1'b0);
        step(1'b0, 1'b1, 15, 1'b0, 1'b0);
        step(1'b0, 1'b1, 15, 1'b0, 1'b0);
        step(1'b0, 1'b1, 15, 1'b0, 1'b1);
        idle(1, 1'b0);

        nxt_exp = -99;
        step(1'b0, 1'b1, 100, 1'b0, 1'b0);
        step(1'b0, 1'b1, 100, 1'b0, 1'b0);
        step(1'b0, 1'b1, 999, 1'b1, 1'b0);
        idle(1, 1'b0);
        burst(8, 8, 8, 8, 8, 1'b1);
        idle(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
